// File: rtl/cic_decim_stage.sv
// Single-stage CIC decimator: comb, integrator, then keep-every-DECIM-th sample.
// Define CIC_SKIP_FIRST_EN to suppress the first output pulse after reset or enable.
module cic_decim_stage #(
  parameter int unsigned I_BW   = 2,
  parameter int unsigned DECIM  = 250,
  parameter int unsigned ACC_BW = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic signed [I_BW-1:0]   data_i,
  input  logic                     valid_i,
  output logic signed [ACC_BW-1:0] data_o,
  output logic                     valid_o
);

  localparam int unsigned CntW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DECIM - 1);

  logic [I_BW-1:0]   dly_q [DECIM];
  logic [I_BW:0]     diff_d, diff_q;
  logic              comb_vld_q;
  logic [ACC_BW-1:0] acc_d, acc_q;
  logic              int_vld_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic              frame_done;
  logic              emit;
  logic [ACC_BW-1:0] data_q;
  logic              valid_q;

  always_comb begin
    diff_d = {data_i[I_BW-1], data_i} - {dly_q[DECIM-1][I_BW-1], dly_q[DECIM-1]};
    acc_d  = acc_q + {{(ACC_BW-I_BW-1){diff_q[I_BW]}}, diff_q};
    frame_done = int_vld_q && (cnt_q == CntMax);
    cnt_d  = cnt_q;
    if (int_vld_q) begin
      cnt_d = frame_done ? '0 : cnt_q + 1'b1;
    end
  end

  // Delay line only moves on qualified samples; disable flushes it to zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < int'(DECIM); k++) dly_q[k] <= '0;
    end else if (!en_i) begin
      for (int k = 0; k < int'(DECIM); k++) dly_q[k] <= '0;
    end else if (valid_i) begin
      dly_q[0] <= data_i;
      for (int k = 1; k < int'(DECIM); k++) dly_q[k] <= dly_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      diff_q     <= '0;
      comb_vld_q <= 1'b0;
      acc_q      <= '0;
      int_vld_q  <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else if (!en_i) begin
      diff_q     <= '0;
      comb_vld_q <= 1'b0;
      acc_q      <= '0;
      int_vld_q  <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      comb_vld_q <= valid_i;
      if (valid_i) diff_q <= diff_d;
      int_vld_q  <= comb_vld_q;
      if (comb_vld_q) acc_q <= acc_d;
      cnt_q      <= cnt_d;
      valid_q    <= frame_done && emit;
      if (frame_done) data_q <= acc_q;
    end
  end

`ifdef CIC_SKIP_FIRST_EN
  logic skip_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skip_q <= 1'b1;
    end else if (!en_i) begin
      skip_q <= 1'b1;
    end else if (frame_done) begin
      skip_q <= 1'b0;
    end
  end

  assign emit = !skip_q;
`else
  assign emit = 1'b1;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_cic_decim_stage.sv
// Directed bench for cic_decim_stage at default parameters; honours CIC_SKIP_FIRST_EN.
module tb_cic_decim_stage;

  localparam int IBw   = 2;
  localparam int Decim = 250;
  localparam int AccBw = 9;
`ifdef CIC_SKIP_FIRST_EN
  localparam int Skip = 1;
`else
  localparam int Skip = 0;
`endif

  logic                    clk_i   = 1'b0;
  logic                    rst_n_i = 1'b0;
  logic                    en_i    = 1'b0;
  logic                    valid_i = 1'b0;
  logic signed [IBw-1:0]   data_i  = '0;
  logic signed [AccBw-1:0] data_o;
  logic                    valid_o;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int pulse_cyc[$];
  int pulse_dat[$];
  int exp_cyc[$];
  int exp_dat[$];

  cic_decim_stage #(
    .I_BW  (IBw),
    .DECIM (Decim),
    .ACC_BW(AccBw)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (en_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .data_o (data_o),
    .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(int'(data_o));
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic [IBw-1:0] d);
    @(posedge clk_i);
    #1;
    valid_i = v;
    data_i  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  // Called right after the step that drives the DECIM-th sample of a frame.
  task automatic expect_at(input int d);
    exp_cyc.push_back(cyc + 3);
    exp_dat.push_back(d);
  endtask

  task automatic clear_en();
    step(1'b0, '0);
    en_i = 1'b0;
    step(1'b0, '0);
    en_i = 1'b1;
  endtask

  task automatic check_frames(input string tag);
    int n;
    if (Skip != 0 && exp_cyc.size() > 0) begin
      void'(exp_cyc.pop_front());
      void'(exp_dat.pop_front());
    end
    chk({tag, "_count"}, pulse_cyc.size(), exp_cyc.size());
    n = (pulse_cyc.size() < exp_cyc.size()) ? pulse_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), pulse_cyc[i], exp_cyc[i]);
      chk($sformatf("%s_dat%0d", tag, i), pulse_dat[i], exp_dat[i]);
    end
    pulse_cyc.delete();
    pulse_dat.delete();
    exp_cyc.delete();
    exp_dat.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_data", int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    rst_n_i = 1'b1;
    en_i    = 1'b1;
    idle(2);
    chk("post_rst_data", int'(data_o), 0);

    // T1: constant ones, two frames
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 2'd1);
      if (i == 249 || i == 499) expect_at(250);
    end
    idle(5);
    chk("t1_hold", int'(data_o), 250);
    check_frames("t1");

    // T2: alternating 1,0 -> 125 per frame
    clear_en();
    for (int i = 0; i < 750; i++) begin
      step(1'b1, (i % 2 == 0) ? 2'd1 : 2'd0);
      if (i == 249 || i == 499 || i == 749) expect_at(125);
    end
    idle(5);
    check_frames("t2");

    // T3: ones then zeros -> 250 then 0
    clear_en();
    for (int i = 0; i < 500; i++) begin
      step(1'b1, (i < 250) ? 2'd1 : 2'd0);
      if (i == 249) expect_at(250);
      if (i == 499) expect_at(0);
    end
    idle(5);
    chk("t3_hold", int'(data_o), 0);
    check_frames("t3");

    // T4: sparse input, idle cycles carry junk that must be ignored
    clear_en();
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 2'd1);
      if (i == 249 || i == 499) expect_at(250);
      if (i != 499) begin
        step(1'b0, 2'b11);
        step(1'b0, 2'b11);
      end
    end
    idle(5);
    chk("t4_hold", int'(data_o), 250);
    check_frames("t4");

    // T5: one-cycle disable mid-frame, valid_i held high across it
    for (int i = 0; i < 100; i++) step(1'b1, 2'd1);
    chk("t5_pre", int'(data_o), 250);
    step(1'b1, 2'd1);
    en_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("t5_dis_data", int'(data_o), 0);
    chk("t5_dis_valid", int'(valid_o), 0);
    en_i    = 1'b1;
    valid_i = 1'b1;
    data_i  = 2'd1;
    for (int i = 1; i < 250; i++) begin
      step(1'b1, 2'd1);
      if (i == 249) expect_at(250);
    end
    idle(5);
    check_frames("t5");

    // T6: async reset landing during an output pulse, mid-frame
    clear_en();
    for (int i = 0; i < 253; i++) step(1'b1, 2'd1);
    chk("t6_pulse_valid", int'(valid_o), 1 - Skip);
    chk("t6_pulse_data", int'(data_o), 250);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("t6_rst_data", int'(data_o), 0);
    chk("t6_rst_valid", int'(valid_o), 0);
    step(1'b0, '0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 250; i++) begin
      step(1'b1, 2'd1);
      if (i == 249) expect_at(250);
    end
    idle(5);
    check_frames("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
